// File: rtl/ring_burst_ctrl_pkg.sv
// Shared types and default widths for the ring injection sequencer.
// Default widths match the ring router's header fields.
package ring_burst_ctrl_pkg;

  localparam int LEN_W_DEF  = 4;
  localparam int DEST_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Counter width able to hold n, never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ring_burst_ctrl_burst_len_counter.sv
// Loadable down-counter with zero/one flags.
// Load wins over enable; the count saturates at zero.
module burst_len_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/ring_burst_ctrl.sv
// Burst sequencer: one request in, head..tail flit stream out,
// followed by a fixed idle gap so the ring arbiter can rotate.
module ring_burst_ctrl
  import ring_burst_ctrl_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int DEST_W     = DEST_W_DEF,
  parameter int GAP_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [LEN_W-1:0]  REQ_LEN,
  input  logic [DEST_W-1:0] REQ_DEST,
  input  logic              ABORT,
  output logic              FLIT_VALID,
  input  logic              FLIT_READY,
  output logic              FLIT_HEAD,
  output logic              FLIT_TAIL,
  output logic [DEST_W-1:0] FLIT_DEST,
  output logic [LEN_W-1:0]  FLIT_SEQ,
  output logic              DONE,
  output logic              ERR,
  output logic              BUSY
);

  localparam int GW = cnt_w(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYCLES);
  localparam state_e END_ST =
    (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_e            state_q, state_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [LEN_W-1:0]  seq_q, seq_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic rem_load, rem_en, rem_zero, rem_one;
  logic gap_load, gap_en, gap_zero, gap_one;

  burst_len_counter #(.W(LEN_W)) u_rem (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (rem_load),
    .load_val_i (REQ_LEN),
    .en_i       (rem_en),
    .zero_o     (rem_zero),
    .one_o      (rem_one)
  );

  burst_len_counter #(.W(GW)) u_gap (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (gap_load),
    .load_val_i (GAP_LD),
    .en_i       (gap_en),
    .zero_o     (gap_zero),
    .one_o      (gap_one)
  );

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    seq_d    = seq_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rem_load = 1'b0;
    rem_en   = 1'b0;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          dest_d   = REQ_DEST;
          seq_d    = '0;
          rem_load = 1'b1;
          if (REQ_LEN != '0) begin
            state_d = ST_SEND;
          end else begin
            done_d   = 1'b1;
            gap_load = 1'b1;
            state_d  = END_ST;
          end
        end
      end
      ST_SEND: begin
        // Abort beats a same-cycle transfer: that flit is not sent.
        if (ABORT) begin
          err_d    = 1'b1;
          gap_load = 1'b1;
          state_d  = END_ST;
        end else if (FLIT_READY) begin
          rem_en = 1'b1;
          seq_d  = seq_q + 1'b1;
          if (rem_one) begin
            done_d   = 1'b1;
            gap_load = 1'b1;
            state_d  = END_ST;
          end
        end
      end
      ST_GAP: begin
        if (gap_one || gap_zero) begin
          state_d = ST_IDLE;
        end else begin
          gap_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      seq_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign REQ_READY  = (state_q == ST_IDLE);
  assign FLIT_VALID = (state_q == ST_SEND) && !rem_zero;
  assign FLIT_HEAD  = FLIT_VALID && (seq_q == '0);
  assign FLIT_TAIL  = FLIT_VALID && rem_one;
  assign FLIT_DEST  = dest_q;
  assign FLIT_SEQ   = seq_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ring_burst_ctrl.sv
// Bench for ring_burst_ctrl: directed bursts, then random bursts
// checked against a per-flit transaction model.
module tb_ring_burst_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [3:0] REQ_LEN;
  logic [2:0] REQ_DEST;
  logic       ABORT;
  logic       FLIT_VALID;
  logic       FLIT_READY;
  logic       FLIT_HEAD;
  logic       FLIT_TAIL;
  logic [2:0] FLIT_DEST;
  logic [3:0] FLIT_SEQ;
  logic       DONE;
  logic       ERR;
  logic       BUSY;

  int passed = 0;
  int total  = 0;

  ring_burst_ctrl #(
    .LEN_W(4), .DEST_W(3), .GAP_CYCLES(1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_LEN    (REQ_LEN),
    .REQ_DEST   (REQ_DEST),
    .ABORT      (ABORT),
    .FLIT_VALID (FLIT_VALID),
    .FLIT_READY (FLIT_READY),
    .FLIT_HEAD  (FLIT_HEAD),
    .FLIT_TAIL  (FLIT_TAIL),
    .FLIT_DEST  (FLIT_DEST),
    .FLIT_SEQ   (FLIT_SEQ),
    .DONE       (DONE),
    .ERR        (ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // mode 0: always ready, 1: fixed pattern 1,0,0,1,1,0,1, 2: random
  task automatic run_burst(input int len, input int dest,
                           input int abort_at, input int mode);
    logic [6:0] pat = 7'b1011001;
    int  k;
    int  stalls;
    int  p;
    bit  rdy;
    bit  ab;
    bit  aborted;
    chk("idle_ready", REQ_READY, 1);
    chk("idle_busy", BUSY, 0);
    REQ_VALID = 1'b1;
    REQ_LEN   = len[3:0];
    REQ_DEST  = dest[2:0];
    step;
    REQ_VALID = 1'b0;
    REQ_LEN   = 4'($urandom);
    REQ_DEST  = 3'($urandom);
    k = 0; stalls = 0; p = 0; aborted = 0;
    while (k < len && !aborted) begin
      chk("flit_valid", FLIT_VALID, 1);
      chk("flit_seq", FLIT_SEQ, k);
      chk("flit_head", FLIT_HEAD, k == 0);
      chk("flit_tail", FLIT_TAIL, k == len - 1);
      chk("flit_dest", FLIT_DEST, dest);
      chk("send_busy", BUSY, 1);
      chk("send_rdy", REQ_READY, 0);
      chk("send_done", DONE, 0);
      chk("send_err", ERR, 0);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = pat[p];
        default: rdy = (stalls >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      p = (p + 1) % 7;
      ab = (k == abort_at);
      FLIT_READY = rdy;
      ABORT = ab;
      step;
      FLIT_READY = 1'($urandom_range(0, 1));
      ABORT = 1'b0;
      if (ab) aborted = 1;
      else if (rdy) begin
        k++;
        stalls = 0;
      end else stalls++;
    end
    chk("end_valid", FLIT_VALID, 0);
    chk("end_done", DONE, !aborted);
    chk("end_err", ERR, aborted);
    chk("gap_busy", BUSY, 1);
    chk("gap_ready", REQ_READY, 0);
    ABORT = 1'($urandom_range(0, 1));
    step;
    ABORT = 1'b0;
    chk("back_ready", REQ_READY, 1);
    chk("back_busy", BUSY, 0);
    chk("back_done", DONE, 0);
    chk("back_err", ERR, 0);
    chk("back_valid", FLIT_VALID, 0);
    ABORT = 1'b1;
    step;
    ABORT = 1'b0;
    chk("idle_abort_ready", REQ_READY, 1);
    chk("idle_abort_err", ERR, 0);
  endtask

  initial begin
    int len;
    int ab_at;
    RST = 1'b1;
    REQ_VALID = 1'b0;
    REQ_LEN = '0;
    REQ_DEST = '0;
    ABORT = 1'b0;
    FLIT_READY = 1'b0;
    repeat (2) step;
    chk("rst_ready", REQ_READY, 1);
    chk("rst_valid", FLIT_VALID, 0);
    chk("rst_head", FLIT_HEAD, 0);
    chk("rst_tail", FLIT_TAIL, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_seq", FLIT_SEQ, 0);
    chk("rst_dest", FLIT_DEST, 0);
    RST = 1'b0;
    step;

    run_burst(3, 5, -1, 0);
    run_burst(1, 2, -1, 0);
    run_burst(4, 7, -1, 1);
    run_burst(0, 3, -1, 0);
    run_burst(5, 1, 2, 0);
    run_burst(15, 6, -1, 0);
    run_burst(2, 4, 0, 0);

    // Reset in the middle of a burst.
    REQ_VALID = 1'b1;
    REQ_LEN = 4'd4;
    REQ_DEST = 3'd6;
    step;
    REQ_VALID = 1'b0;
    FLIT_READY = 1'b1;
    chk("mid_seq0", FLIT_SEQ, 0);
    step;
    chk("mid_seq1", FLIT_SEQ, 1);
    RST = 1'b1;
    step;
    RST = 1'b0;
    FLIT_READY = 1'b0;
    chk("mid_rst_ready", REQ_READY, 1);
    chk("mid_rst_valid", FLIT_VALID, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_err", ERR, 0);
    chk("mid_rst_seq", FLIT_SEQ, 0);
    chk("mid_rst_dest", FLIT_DEST, 0);
    chk("mid_rst_head", FLIT_HEAD, 0);
    step;
    chk("mid_rst_done2", DONE, 0);
    chk("mid_rst_err2", ERR, 0);
    run_burst(3, 2, -1, 0);

    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(0, 15);
      ab_at = -1;
      if (len > 0 && $urandom_range(0, 3) == 0)
        ab_at = $urandom_range(0, len - 1);
      run_burst(len, $urandom_range(0, 7), ab_at, 2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
